lc4_insn_encoder: RTL and testbench

Field-level instruction encoder for the 20-bit LC4/ECC ISA. Accepts decoded instruction fields (opcode, rd, rs, rt, signed immediate) over a valid/ready handshake, then range-checks and packs them into 20-bit instruction words. Valid words are buffered in a small FIFO and presented on a valid/ready output port that feeds instruction-memory load logic. It is the producer end of the instruction format consumed by the core's decoder.

---
 rtl/lc4_insn_encoder.sv | 127 ++++++++++++
 tb/tb_lc4_insn_encoder.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/lc4_insn_encoder.sv
// lc4_insn_encoder: range-checks decoded LC4/ECC instruction fields, packs them
// into 20-bit instruction words and queues valid words in a small FIFO for
// the instruction-memory loader.
//
// Handshake semantics (both ports): a transfer happens on a rising clk edge
// where valid & ready are both high; valid must not depend on ready, and the
// sender holds its payload stable while valid=1 and ready=0.
module lc4_insn_encoder #(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [4:0]                 in_op,
  input  logic [4:0]                 in_rd,
  input  logic [4:0]                 in_rs,
  input  logic [4:0]                 in_rt,
  input  logic [15:0]                in_imm,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [19:0]                out_insn,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       err_pulse,
  output logic [7:0]                 err_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [19:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  logic [19:0] enc_word;
  logic        enc_ok;
  logic        fits5;
  logic        fits10;
  logic        fits15;
  logic        accept;
  logic        push;
  logic        pop;
  logic        rejected;

  // An immediate fits an N-bit signed field when every bit above N-1 copies bit N-1.
  assign fits5  = (&in_imm[15:4])  | ~(|in_imm[15:4]);
  assign fits10 = (&in_imm[15:9])  | ~(|in_imm[15:9]);
  assign fits15 = (&in_imm[15:14]) | ~(|in_imm[15:14]);

  // Select the encoding format from the opcode and decide whether the bundle is legal.
  always_comb begin
    enc_word = '0;
    enc_ok   = 1'b0;
    case (in_op)
      5'b00101, 5'b00110, 5'b01100, 5'b01101, 5'b01110,
      5'b01111, 5'b10010, 5'b10100, 5'b10101: begin
        enc_word = {in_op, in_rd, in_rs, in_rt};
        enc_ok   = 1'b1;
      end
      5'b00111, 5'b01001: begin
        enc_word = {in_op, in_rd, in_rs, in_imm[4:0]};
        enc_ok   = fits5;
      end
      5'b10000, 5'b10011: begin
        enc_word = {in_op, in_rd, in_rs, 5'b00000};
        enc_ok   = 1'b1;
      end
      5'b01011: begin
        enc_word = {in_op, in_rd, in_imm[9:0]};
        enc_ok   = fits10;
      end
      5'b00000, 5'b00001, 5'b00010, 5'b00011, 5'b00100, 5'b01000: begin
        enc_word = {in_op, in_imm[14:0]};
        enc_ok   = fits15;
      end
      5'b01010: begin
        enc_word = {in_op, 15'b0};
        enc_ok   = 1'b1;
      end
      default: begin
        enc_word = '0;
        enc_ok   = 1'b0;
      end
    endcase
  end

  // Ready depends only on stored occupancy: a pop while full does not open the input that cycle.
  assign in_ready  = (count != FULL);
  assign out_valid = (count != '0);
  assign out_insn  = mem[rd_ptr];

  assign accept   = in_valid & in_ready;
  assign push     = accept & enc_ok;
  assign rejected = accept & ~enc_ok;
  assign pop      = out_valid & out_ready;

  // FIFO storage, pointers and occupancy; rejected bundles are consumed but never stored.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= enc_word;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      if (push && !pop)      count <= count + CW'(1);
      else if (pop && !push) count <= count - CW'(1);
    end
  end

  // Reject reporting: one-cycle pulse after the rejecting edge, saturating counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_pulse <= 1'b0;
      err_count <= '0;
    end else begin
      err_pulse <= rejected;
      if (rejected && err_count != 8'hFF) err_count <= err_count + 8'd1;
    end
  end

endmodule

// File: tb/tb_lc4_insn_encoder.sv
// Testbench for lc4_insn_encoder: driver tasks feed field bundles, a reference
// encoder pushes expected words into exp_q at accepting edges, and the monitor
// pops and compares them when the DUT pops its FIFO head.
module tb_lc4_insn_encoder;

  localparam int DEPTH = 4;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_op;
  logic [4:0]  in_rd;
  logic [4:0]  in_rs;
  logic [4:0]  in_rt;
  logic [15:0] in_imm;
  logic        out_valid;
  logic        out_ready;
  logic [19:0] out_insn;
  logic [2:0]  count;
  logic        err_pulse;
  logic [7:0]  err_count;

  lc4_insn_encoder #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_rd(in_rd), .in_rs(in_rs), .in_rt(in_rt), .in_imm(in_imm),
    .out_valid(out_valid), .out_ready(out_ready), .out_insn(out_insn),
    .count(count), .err_pulse(err_pulse), .err_count(err_count)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  logic [19:0] exp_q[$];
  logic        exp_pulse;
  int          exp_err;
  int          n_cmp;
  int          n_err;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Reference encoder: returns {legal, word}; range checks done on signed integers.
  function automatic logic [20:0] model(input logic [4:0] op, input logic [4:0] rd,
                                        input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [15:0] imm);
    int si;
    si = int'($signed(imm));
    case (op)
      5'd5, 5'd6, 5'd12, 5'd13, 5'd14, 5'd15, 5'd18, 5'd20, 5'd21:
        return {1'b1, op, rd, rs, rt};
      5'd7, 5'd9:
        return {(si >= -16 && si <= 15), op, rd, rs, imm[4:0]};
      5'd16, 5'd19:
        return {1'b1, op, rd, rs, 5'd0};
      5'd11:
        return {(si >= -512 && si <= 511), op, rd, imm[9:0]};
      5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd8:
        return {(si >= -16384 && si <= 16383), op, imm[14:0]};
      5'd10:
        return {1'b1, op, 15'd0};
      default:
        return {1'b0, 20'd0};
    endcase
  endfunction

  // Monitor: at each falling edge decide what the next rising edge will do.
  always @(negedge clk) begin
    logic [20:0] r;
    if (!rst) begin
      check("err_pulse", err_pulse, exp_pulse);
      if (out_valid && out_ready) begin
        check("pop_q_nonempty", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) check("out_insn", out_insn, exp_q.pop_front());
      end
      exp_pulse = 1'b0;
      if (in_valid && in_ready) begin
        r = model(in_op, in_rd, in_rs, in_rt, in_imm);
        if (r[20]) exp_q.push_back(r[19:0]);
        else begin
          exp_pulse = 1'b1;
          if (exp_err < 255) exp_err++;
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  // All drivers start and end just after a rising edge.
  task automatic send(input logic [4:0] op, input logic [4:0] rd, input logic [4:0] rs,
                      input logic [4:0] rt, input logic [15:0] imm);
    int n;
    n = 0;
    in_op = op; in_rd = rd; in_rs = rs; in_rt = rt; in_imm = imm;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) check("send_ready", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic reject();
    send(5'b10001, 5'd0, 5'd0, 5'd0, 16'd0);
  endtask

  task automatic wait_count(input int target, input int budget);
    int n;
    n = 0;
    while (count !== target[2:0] && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("wait_count", count, target);
    @(posedge clk); #1;
  endtask

  task automatic pop_one();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"}, in_ready, 1);
    check({tag, "_out_valid"}, out_valid, 0);
    check({tag, "_out_insn"}, out_insn, 0);
    check({tag, "_count"}, count, 0);
    check({tag, "_err_pulse"}, err_pulse, 0);
    check({tag, "_err_count"}, err_count, 0);
  endtask

  // Asynchronous reset applied mid-cycle, released shortly after a rising edge.
  task automatic do_reset(input string tag);
    rst = 1'b1;
    #1;
    check_reset_outputs(tag);
    exp_q.delete();
    exp_pulse = 1'b0;
    exp_err   = 0;
    @(posedge clk); #2;
    rst = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [19:0] held;
    logic [4:0]  rop;
    n_cmp = 0; n_err = 0; exp_err = 0; exp_pulse = 1'b0;
    in_valid = 1'b0; out_ready = 1'b0;
    in_op = '0; in_rd = '0; in_rs = '0; in_rt = '0; in_imm = '0;
    rst = 1'b1;
    #12;
    do_reset("rst0");

    // Single ADD: one-cycle latency, then pop.
    send(5'b00101, 5'd3, 5'd4, 5'd5, 16'd0);
    @(negedge clk);
    check("add_valid", out_valid, 1);
    check("add_insn", out_insn, 20'h28C85);
    check("add_count", count, 1);
    @(posedge clk); #1;
    pop_one();
    check("add_pop_count", count, 0);

    // CONST -1 accepted, CONST 512 rejected.
    send(5'b01011, 5'd1, 5'd0, 5'd0, 16'hFFFF);
    @(negedge clk);
    check("const_insn", out_insn, 20'h587FF);
    @(posedge clk); #1;
    pop_one();
    send(5'b01011, 5'd1, 5'd0, 5'd0, 16'd512);
    @(negedge clk);
    check("const512_pulse", err_pulse, 1);
    check("const512_errcnt", err_count, 1);
    check("const512_count", count, 0);
    @(negedge clk);
    check("const512_pulse_end", err_pulse, 0);
    @(posedge clk); #1;

    // ADDI boundaries and an illegal opcode.
    send(5'b00111, 5'd2, 5'd6, 5'd0, 16'd15);
    send(5'b00111, 5'd2, 5'd6, 5'd0, 16'hFFF0);
    send(5'b00111, 5'd2, 5'd6, 5'd0, 16'd16);
    reject();
    @(negedge clk);
    check("addi_count", count, 2);
    check("addi_head", out_insn, {5'b00111, 5'd2, 5'd6, 5'b01111});
    check("addi_errcnt", err_count, 3);
    @(posedge clk); #1;
    pop_one();
    @(negedge clk);
    check("addi_head2", out_insn, {5'b00111, 5'd2, 5'd6, 5'b10000});
    @(posedge clk); #1;
    pop_one();

    // Random bundles across every opcode and immediates spanning the limits.
    out_ready = 1'b1;
    for (int i = 0; i < 40; i++)
      send(5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
           5'($urandom_range(0, 31)), 16'($urandom_range(0, 1200) - 600));
    for (int i = 0; i < 10; i++)
      send(5'($urandom_range(0, 8)), 5'd0, 5'd0, 5'd0, 16'($urandom_range(16380, 16388)));
    wait_count(0, 20);
    out_ready = 1'b0;
    check("rand_errcnt", err_count, exp_err);

    // Fill to DEPTH with the output stalled; the fifth bundle waits.
    for (int i = 0; i < 4; i++) send(5'b00110, 5'(i), 5'(i + 8), 5'(i + 16), 16'd0);
    check("full_count", count, 4);
    held = exp_q[0];
    in_op = 5'b10100; in_rd = 5'd9; in_rs = 5'd10; in_rt = 5'd11; in_imm = 16'd0;
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("full_in_ready", in_ready, 0);
      check("full_stable", out_insn, held);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("full_after_pop_count", count, 3);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("full_fifth_count", count, 4);
    out_ready = 1'b1;
    wait_count(0, 20);
    out_ready = 1'b0;

    // Steady state at count=2: accept and pop on the same edge.
    send(5'b01100, 5'd1, 5'd1, 5'd1, 16'd0);
    send(5'b01101, 5'd2, 5'd2, 5'd2, 16'd0);
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      send(5'b00101, 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
           5'($urandom_range(0, 31)), 16'd0);
      check("steady_count", count, 2);
    end
    wait_count(0, 20);
    out_ready = 1'b0;

    // Asynchronous reset with words queued and err_count=7.
    do_reset("rst1");
    for (int i = 0; i < 7; i++) reject();
    for (int i = 0; i < 3; i++) send(5'b01010, 5'd0, 5'd0, 5'd0, 16'd0);
    check("pre_rst_count", count, 3);
    check("pre_rst_errcnt", err_count, 7);
    @(posedge clk); #3;
    do_reset("rst_async");

    // Saturation of the reject counter.
    for (int i = 0; i < 260; i++) reject();
    @(negedge clk);
    check("sat_errcnt", err_count, 255);
    check("sat_model", err_count, exp_err);
    check("sat_count", count, 0);
    @(posedge clk); #1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
